// File: rtl/bus_arbiter.sv
// bus_arbiter: hands the shared system bus to one of NUM_MASTERS masters, round-robin, with split/recall.
// Latency: one cycle from request to grant; one dead TURN cycle after every release, split or revoke.
// Backpressure: a master holds mreq for its whole transaction; a split parks the owner until split_done.
//
// Ports:
//   clk, rstn           system clock, asynchronous active-low reset
//   mreq                per-master request, held high for the whole transaction
//   split               one-cycle pulse from the addressed slave: park the current owner
//   split_done(_id)     one-cycle pulse from a slave: the parked master (by index) may resume
//   mgrant              one-hot grant, all zero when idle
//   owner               index of the granted master, or of the last one when idle
//   bus_busy            high while any grant is active
//   split_pending       masters currently parked by a split
//   timeout             one-cycle pulse when the watchdog revokes a grant
//
// Optional feature macro: ARB_TIMEOUT_EN adds the ownership watchdog (TIMEOUT cycles) and the
// blocked-master mask. Without it, ownership is unlimited and timeout is tied low.
module bus_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int TIMEOUT     = 256
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic [NUM_MASTERS-1:0]         mreq,
   input  logic                           split,
   input  logic                           split_done,
   input  logic [$clog2(NUM_MASTERS)-1:0] split_done_id,
   output logic [NUM_MASTERS-1:0]         mgrant,
   output logic [$clog2(NUM_MASTERS)-1:0] owner,
   output logic                           bus_busy,
   output logic [NUM_MASTERS-1:0]         split_pending,
   output logic                           timeout
);

   localparam int ID_W = $clog2(NUM_MASTERS);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_TURN = 2'd2;

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT < 4) begin : g_param_check
      $error("bus_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT at least 4");
   end

   // Returns {found, index} of the first set bit of cand, scanning upward from start with wrap.
   // The scan runs from the farthest offset down so the nearest candidate is written last.
   function automatic logic [ID_W:0] rr_pick(input logic [NUM_MASTERS-1:0] cand,
                                             input logic [ID_W-1:0]        start);
      logic [ID_W:0] res;
      int            idx;
      res = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         idx = int'(start) + i;
         if (idx >= NUM_MASTERS) begin
            idx = idx - NUM_MASTERS;
         end
         if (cand[idx]) begin
            res = {1'b1, idx[ID_W-1:0]};
         end
      end
      return res;
   endfunction

   logic [1:0]             state_q,  state_d;
   logic [NUM_MASTERS-1:0] mgrant_q, mgrant_d;
   logic [ID_W-1:0]        owner_q,  owner_d;
   logic                   busy_q,   busy_d;
   logic [NUM_MASTERS-1:0] pend_q,   pend_d;
   logic [NUM_MASTERS-1:0] recall_q, recall_d;
   logic [ID_W-1:0]        rr_q,     rr_d;

   logic [NUM_MASTERS-1:0] elig;
   logic [NUM_MASTERS-1:0] rec_cand;
   logic [NUM_MASTERS-1:0] done_mask;
   logic [ID_W:0]          pick;
   logic [ID_W-1:0]        sel;
   logic                   leave;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT);

   logic [CNT_W-1:0]       cnt_q,     cnt_d;
   logic [NUM_MASTERS-1:0] blocked_q, blocked_d;
   logic                   timeout_q, timeout_d;
`endif

   // Only a master that is actually parked can be recalled; ids that match nothing
   // (not pending, or beyond NUM_MASTERS-1) simply produce an empty mask.
   always_comb begin
      done_mask = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (split_done && (split_done_id == ID_W'(i)) && pend_q[i]) begin
            done_mask[i] = 1'b1;
         end
      end
   end

   // Recalled masters outrank plain round-robin; among several recalls the
   // round-robin pointer still decides.
   always_comb begin
`ifdef ARB_TIMEOUT_EN
      elig = mreq & ~pend_q & ~blocked_q;
`else
      elig = mreq & ~pend_q;
`endif
      rec_cand = elig & recall_q;
      if (|rec_cand) begin
         pick = rr_pick(rec_cand, rr_q);
      end else begin
         pick = rr_pick(elig, rr_q);
      end
      sel = pick[ID_W-1:0];
   end

   always_comb begin
      state_d  = state_q;
      mgrant_d = mgrant_q;
      owner_d  = owner_q;
      busy_d   = busy_q;
      rr_d     = rr_q;
      pend_d   = pend_q & ~done_mask;
      recall_d = recall_q | done_mask;
      leave    = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      // A revoked master is released from the block as soon as its request is seen low.
      blocked_d = blocked_q & mreq;
      timeout_d = 1'b0;
`endif

      case (state_q)
         // TURN arbitrates just like IDLE so the next grant lands right after the dead cycle.
         ST_IDLE, ST_TURN: begin
            if (pick[ID_W]) begin
               state_d       = ST_BUSY;
               mgrant_d      = '0;
               mgrant_d[sel] = 1'b1;
               owner_d       = sel;
               busy_d        = 1'b1;
               rr_d          = (sel == ID_W'(NUM_MASTERS - 1)) ? '0 : sel + ID_W'(1);
               recall_d[sel] = 1'b0;
`ifdef ARB_TIMEOUT_EN
               cnt_d         = '0;
`endif
            end else begin
               state_d  = ST_IDLE;
               mgrant_d = '0;
               busy_d   = 1'b0;
            end
         end

         ST_BUSY: begin
            // Release outranks split, which outranks the watchdog.
            if (!mreq[owner_q]) begin
               leave = 1'b1;
            end else if (split) begin
               leave           = 1'b1;
               pend_d[owner_q] = 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               leave              = 1'b1;
               timeout_d          = 1'b1;
               blocked_d[owner_q] = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
            if (leave) begin
               state_d  = ST_TURN;
               mgrant_d = '0;
               busy_d   = 1'b0;
            end
         end

         default: begin
            state_d  = ST_IDLE;
            mgrant_d = '0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         mgrant_q <= '0;
         owner_q  <= '0;
         busy_q   <= 1'b0;
         pend_q   <= '0;
         recall_q <= '0;
         rr_q     <= '0;
      end else begin
         state_q  <= state_d;
         mgrant_q <= mgrant_d;
         owner_q  <= owner_d;
         busy_q   <= busy_d;
         pend_q   <= pend_d;
         recall_q <= recall_d;
         rr_q     <= rr_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q     <= '0;
         blocked_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         blocked_q <= blocked_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign mgrant        = mgrant_q;
   assign owner         = owner_q;
   assign bus_busy      = busy_q;
   assign split_pending = pend_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of grant order, dead cycles, split/recall and reset for bus_arbiter.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bus_arbiter;

   localparam int N = 2;

   logic         clk = 1'b0;
   logic         rstn;
   logic [N-1:0] mreq;
   logic         split;
   logic         split_done;
   logic [0:0]   split_done_id;
   logic [N-1:0] mgrant;
   logic [0:0]   owner;
   logic         bus_busy;
   logic [N-1:0] split_pending;
   logic         timeout;

   int checks = 0;
   int errors = 0;

   logic [1:0] exp_g;
   logic       exp_o;
   logic       timeout_seen;

   bus_arbiter #(
      .NUM_MASTERS(N),
      .TIMEOUT    (8)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .mreq         (mreq),
      .split        (split),
      .split_done   (split_done),
      .split_done_id(split_done_id),
      .mgrant       (mgrant),
      .owner        (owner),
      .bus_busy     (bus_busy),
      .split_pending(split_pending),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_bus(input string tag, input logic [1:0] g, input logic own,
                            input logic busy, input logic [1:0] pend);
      check({tag, "/mgrant"},        32'(mgrant),        32'(g));
      check({tag, "/owner"},         32'(owner),         32'(own));
      check({tag, "/bus_busy"},      32'(bus_busy),      32'(busy));
      check({tag, "/split_pending"}, 32'(split_pending), 32'(pend));
   endtask

   initial begin
      rstn          = 1'b0;
      mreq          = '0;
      split         = 1'b0;
      split_done    = 1'b0;
      split_done_id = '0;
      timeout_seen  = 1'b0;
      exp_g         = '0;
      exp_o         = 1'b0;
      repeat (2) tick();
      check_bus("reset", 2'b00, 1'b0, 1'b0, 2'b00);
      check("reset/timeout", 32'(timeout), 32'd0);
      rstn = 1'b1;

      // Both request: m0 first, m0 drops, dead cycle, then m1.
      mreq = 2'b11;
      tick(); check_bus("A.grant_m0", 2'b01, 1'b0, 1'b1, 2'b00);
      mreq = 2'b10;
      tick(); check_bus("A.turn", 2'b00, 1'b0, 1'b0, 2'b00);
      tick(); check_bus("A.grant_m1", 2'b10, 1'b1, 1'b1, 2'b00);
      mreq = 2'b00;
      tick(); check_bus("A.release", 2'b00, 1'b1, 1'b0, 2'b00);
      tick(); check_bus("A.idle", 2'b00, 1'b1, 1'b0, 2'b00);

      // Continuous requests, 5-cycle transactions: grants alternate with one dead cycle.
      mreq = 2'b11;
      for (int t = 0; t < 3; t++) begin
         exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
         exp_o = (t % 2 == 1);
         tick(); check_bus($sformatf("B.grant%0d", t), exp_g, exp_o, 1'b1, 2'b00);
         repeat (4) tick();
         check_bus($sformatf("B.hold%0d", t), exp_g, exp_o, 1'b1, 2'b00);
         mreq = 2'b11 & ~exp_g;
         tick(); check_bus($sformatf("B.dead%0d", t), 2'b00, exp_o, 1'b0, 2'b00);
         mreq = 2'b11;
      end
      mreq = 2'b00;
      tick(); check_bus("B.idle", 2'b00, 1'b0, 1'b0, 2'b00);

      // Split m0, m1 runs, m0 recalled during m1's transaction and granted next.
      mreq = 2'b01;
      tick(); check_bus("C.grant_m0", 2'b01, 1'b0, 1'b1, 2'b00);
      split = 1'b1;
      tick(); check_bus("C.split", 2'b00, 1'b0, 1'b0, 2'b01);
      split = 1'b0;
      mreq  = 2'b11;
      tick(); check_bus("C.grant_m1", 2'b10, 1'b1, 1'b1, 2'b01);
      split_done    = 1'b1;
      split_done_id = 1'b0;
      tick(); check_bus("C.done", 2'b10, 1'b1, 1'b1, 2'b00);
      split_done = 1'b0;
      tick(); check_bus("C.m1_hold", 2'b10, 1'b1, 1'b1, 2'b00);
      mreq = 2'b01;
      tick(); check_bus("C.m1_release", 2'b00, 1'b1, 1'b0, 2'b00);
      tick(); check_bus("C.recall_grant", 2'b01, 1'b0, 1'b1, 2'b00);

      // Split coinciding with release is ignored; split_done for a non-pending master is ignored.
      mreq  = 2'b00;
      split = 1'b1;
      tick(); check_bus("D.split_vs_release", 2'b00, 1'b0, 1'b0, 2'b00);
      split         = 1'b0;
      split_done    = 1'b1;
      split_done_id = 1'b1;
      tick(); check_bus("D.done_not_pending", 2'b00, 1'b0, 1'b0, 2'b00);
      split_done = 1'b0;
      split      = 1'b1;
      tick(); check_bus("D.split_idle", 2'b00, 1'b0, 1'b0, 2'b00);
      split = 1'b0;

      // Parked master keeps its pending bit while idle; recall lands two edges after split_done.
      mreq = 2'b01;
      tick(); check_bus("E.grant_m0", 2'b01, 1'b0, 1'b1, 2'b00);
      split = 1'b1;
      tick(); check_bus("E.split", 2'b00, 1'b0, 1'b0, 2'b01);
      split = 1'b0;
      tick(); check_bus("E.parked", 2'b00, 1'b0, 1'b0, 2'b01);
      mreq = 2'b00;
      tick(); check_bus("E.parked_drop", 2'b00, 1'b0, 1'b0, 2'b01);
      mreq          = 2'b01;
      split_done    = 1'b1;
      split_done_id = 1'b0;
      tick(); check_bus("E.done", 2'b00, 1'b0, 1'b0, 2'b00);
      split_done = 1'b0;
      tick(); check_bus("E.recall_grant", 2'b01, 1'b0, 1'b1, 2'b00);

      // Asynchronous reset while m1 owns the bus and m0 is parked.
      mreq  = 2'b11;
      split = 1'b1;
      tick(); check_bus("F.split", 2'b00, 1'b0, 1'b0, 2'b01);
      split = 1'b0;
      tick(); check_bus("F.grant_m1", 2'b10, 1'b1, 1'b1, 2'b01);
      #2;
      rstn = 1'b0;
      #1;
      check_bus("F.async_reset", 2'b00, 1'b0, 1'b0, 2'b00);
      check("F.async_reset/timeout", 32'(timeout), 32'd0);
      tick();
      rstn = 1'b1;
      mreq = 2'b01;
      tick(); check_bus("F.after_reset", 2'b01, 1'b0, 1'b1, 2'b00);

`ifdef ARB_TIMEOUT_EN
      // Watchdog with TIMEOUT=8: m0 granted at the last edge, revoked 8 edges later.
      mreq = 2'b11;
      repeat (7) tick();
      check_bus("G.before_expiry", 2'b01, 1'b0, 1'b1, 2'b00);
      check("G.before_expiry/timeout", 32'(timeout), 32'd0);
      tick(); check_bus("G.revoke", 2'b00, 1'b0, 1'b0, 2'b00);
      check("G.revoke/timeout", 32'(timeout), 32'd1);
      tick(); check_bus("G.grant_m1", 2'b10, 1'b1, 1'b1, 2'b00);
      check("G.pulse_end/timeout", 32'(timeout), 32'd0);
      mreq = 2'b01;
      tick(); check_bus("G.m1_release", 2'b00, 1'b1, 1'b0, 2'b00);
      tick(); check_bus("G.m0_blocked", 2'b00, 1'b1, 1'b0, 2'b00);
      mreq = 2'b00;
      tick();
      mreq = 2'b01;
      tick(); check_bus("G.m0_unblocked", 2'b01, 1'b0, 1'b1, 2'b00);
`else
      // No watchdog: ownership is unlimited and timeout never pulses.
      mreq = 2'b11;
      for (int c = 0; c < 300; c++) begin
         tick();
         if (timeout !== 1'b0) timeout_seen = 1'b1;
      end
      check("G.no_timeout", 32'(timeout_seen), 32'd0);
      check_bus("G.unlimited", 2'b01, 1'b0, 1'b1, 2'b00);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
